adder_pipe_nbits: RTL and testbench
===================================

// Module: adder_pipe_nbits
// PURPOSE
//   Parametrised, pipelined carry-chain adder: generalises the fixed 4-bit chain adder
//   to WIDTH bits with carry-in and carry-out.
//   The carry chain is cut into CHUNK-bit slices, one slice per pipeline stage, with the
//   carry registered between stages.
//   A valid/ready handshake on both sides lets the block sit between datapath stages
//   that may stall.
// PARAMETERS
//   WIDTH   16  operand/sum width in bits; must be a multiple of CHUNK
//   CHUNK    4  bits added per pipeline stage; STAGES = WIDTH/CHUNK (localparam, >=1)
// PORTS
//   clk        in   1      rising-edge clock, sole clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      a/b/cin carry a valid operand set
//   in_ready   out  1      block accepts an operand set this cycle
//   a          in   WIDTH  operand A (unsigned)
//   b          in   WIDTH  operand B (unsigned)
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout hold a valid result
//   out_ready  in   1      downstream accepts the result this cycle
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset (rst=1 at clk edge):
//   - All stage valid flags, sum and cout are cleared to 0. In-flight data is discarded.
//   - in_ready is forced to 0 while rst is high.
//   Advance enable:
//   - adv = !out_valid | out_ready (combinational).
//   - in_ready = adv & !rst.
//   - All pipeline registers load only when adv=1; otherwise every stage, sum and cout hold.
//   Transfer rules:
//   - Input transfer: in_valid & in_ready.
//   - Output transfer: out_valid & out_ready.
//   - Stage-0 valid is loaded with the input-transfer flag, so a cycle with no input
//     transfer inserts a bubble.
//   Stage k (k = 0..STAGES-1), on each advance:
//   - Adds a/b bits [k*CHUNK +: CHUNK] plus the carry from stage k-1 (cin for k=0),
//     giving a CHUNK-bit partial sum and a carry.
//   - Upper operand slices not yet consumed are delayed with the stage (skew registers).
//   - Lower partial sums already produced are carried forward (de-skew registers).
//   - The last stage drives the sum and cout registers directly.
//   Timing:
//   - Latency: a set accepted at edge t appears on out_valid/sum/cout after edge
//     t+STAGES-1 (visible in cycle t+STAGES), provided adv stays 1.
//   - Each cycle with adv=0 adds one cycle.
//   - Throughput is one result per cycle when out_ready=1.
//   Output rules:
//   - sum/cout are stable while out_valid=1 and out_ready=0.
//   - The result is held until it is taken; no result is dropped or duplicated.
//   - Results leave in the order their operands were accepted.
//   - With out_valid=0, sum and cout keep their last value; they change only on advance.
//   - Arithmetic is unsigned, modulo 2^WIDTH; cout is the true bit WIDTH.
//   - a=b=all-ones with cin=1 gives sum=all-ones, cout=1.
//   Boundary cases:
//   - Full pipe with out_ready low: the whole pipe freezes and in_ready=0.
//   - Simultaneous output and input transfer in the same cycle is allowed.
//   - rst mid-stream: the next cycle shows out_valid=0, and operand acceptance resumes
//     the cycle after rst falls.
//   - STAGES=1 degenerates to a single registered adder with latency 1.
// TESTING  (WIDTH=16, CHUNK=4 unless noted)
//   1 a=16'hFFFF b=16'h0001 cin=0 accepted at t -> out_valid at t+4, sum=16'h0000 cout=1
//   2 a=16'h1234 b=16'h0FED cin=1 -> sum=16'h2222 cout=0; a=b=16'hFFFF cin=1 -> 16'hFFFF, cout=1
//   3 8 back-to-back sets, out_ready=1 -> 8 results on 8 consecutive cycles, in order, no gaps
//   4 full pipe, out_ready=0 for 3 cycles -> in_ready=0, sum/cout frozen; no loss or repeat after release
//   5 rst for 1 cycle with 3 sets in flight -> out_valid=0 next cycle; none of the 3 ever emerge
//   6 WIDTH=8 CHUNK=8 and WIDTH=32 CHUNK=8: 10k random sets, random out_ready -> match a+b+cin, latency STAGES

Source files
------------

// File: rtl/adder_pipe_nbits.sv
// Pipelined carry-chain adder: WIDTH-bit a + b + cin, CHUNK bits per stage,
// carry registered between stages, valid/ready handshake on both sides.
module adder_pipe_nbits #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int STAGES = WIDTH / CHUNK;

   // Per-stage registers: valid flag, carry out of the slice, partial sum
   // (de-skew, lower slices already produced) and delayed operands (skew).
   logic             validQ [STAGES];
   logic             carryQ [STAGES];
   logic [WIDTH-1:0] sumQ   [STAGES];
   logic [WIDTH-1:0] aQ     [STAGES];
   logic [WIDTH-1:0] bQ     [STAGES];

   logic adv;

   // The whole pipe moves together; it only stalls when a finished result
   // is sitting at the output and nobody takes it.
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv && !rst;
   assign out_valid = validQ[STAGES-1];
   assign sum       = sumQ[STAGES-1];
   assign cout      = carryQ[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : gStage
      localparam int LO = k * CHUNK;

      logic [CHUNK-1:0] sliceA;
      logic [CHUNK-1:0] sliceB;
      logic             prevCarry;
      logic             prevValid;
      logic [WIDTH-1:0] prevSum;
      logic [WIDTH-1:0] nextSum;
      logic [CHUNK:0]   part;

      if (k == 0) begin : gHead
         assign sliceA    = a[LO +: CHUNK];
         assign sliceB    = b[LO +: CHUNK];
         assign prevCarry = cin;
         assign prevValid = in_valid && in_ready;
         assign prevSum   = '0;

         if (STAGES > 1) begin : gSkew
            // Stage 0 captures the full operands so later stages can
            // consume their upper slices.
            always_ff @(posedge clk) begin
               if (!rst && adv) begin
                  aQ[0] <= a;
                  bQ[0] <= b;
               end
            end
         end
      end else begin : gBody
         assign sliceA    = aQ[k-1][LO +: CHUNK];
         assign sliceB    = bQ[k-1][LO +: CHUNK];
         assign prevCarry = carryQ[k-1];
         assign prevValid = validQ[k-1];
         assign prevSum   = sumQ[k-1];

         if (k < STAGES - 1) begin : gSkew
            // Operands ride along with their set until the last stage
            // that still needs an unconsumed slice.
            always_ff @(posedge clk) begin
               if (!rst && adv) begin
                  aQ[k] <= aQ[k-1];
                  bQ[k] <= bQ[k-1];
               end
            end
         end
      end

      assign part = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, prevCarry};

      // Drop this stage's partial sum into its slice of the running result.
      always_comb begin
         nextSum               = prevSum;
         nextSum[LO +: CHUNK]  = part[CHUNK-1:0];
      end

      // Stage register: cleared by reset, loads only when the pipe advances.
      always_ff @(posedge clk) begin
         if (rst) begin
            validQ[k] <= 1'b0;
            carryQ[k] <= 1'b0;
            sumQ[k]   <= '0;
         end else if (adv) begin
            validQ[k] <= prevValid;
            carryQ[k] <= part[CHUNK];
            sumQ[k]   <= nextSum;
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe_nbits.sv
// Self-checking bench for adder_pipe_nbits (WIDTH=16, CHUNK=4): scoreboard of
// expected results, directed cases plus a randomised stall/bubble run.
module tb_adder_pipe_nbits;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   bit chkLat = 1'b0;
   bit afterRst = 1'b0;

   logic [WIDTH:0] expQ[$];
   int             accQ[$];

   adder_pipe_nbits #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .cin(cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .cout(cout)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Hard stop in case something stalls forever.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs after the rising edge, then at the falling
   // edge score whatever transfers will happen on the next rising edge.
   task automatic applyStimulus(input logic iRst, input logic iValid,
                                input logic [WIDTH-1:0] iA, input logic [WIDTH-1:0] iB,
                                input logic iCin, input logic iReady);
      int acc;
      @(posedge clk);
      #1;
      rst       = iRst;
      in_valid  = iValid;
      a         = iA;
      b         = iB;
      cin       = iCin;
      out_ready = iReady;
      cycle++;
      @(negedge clk);
      if (afterRst) begin
         checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
         checkOutput("post_reset_sum", 32'(sum), 32'd0);
         checkOutput("post_reset_cout", 32'(cout), 32'd0);
         if (!iRst) checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
         afterRst = 1'b0;
      end
      if (iRst) begin
         checkOutput("in_ready_in_reset", 32'(in_ready), 32'd0);
         expQ.delete();
         accQ.delete();
         afterRst = 1'b1;
      end else begin
         if (out_valid) begin
            checkOutput("result_pending", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
               checkOutput("sum", 32'(sum), 32'(expQ[0][WIDTH-1:0]));
               checkOutput("cout", 32'(cout), 32'(expQ[0][WIDTH]));
               if (out_ready) begin
                  void'(expQ.pop_front());
                  acc = accQ.pop_front();
                  if (chkLat) checkOutput("latency", 32'(cycle - acc), 32'(STAGES));
               end
            end
         end
         if (in_valid && in_ready) begin
            expQ.push_back({1'b0, iA} + {1'b0, iB} + {{WIDTH{1'b0}}, iCin});
            accQ.push_back(cycle);
         end
      end
   endtask

   task automatic drainPipe();
      for (int i = 0; i < 40 && expQ.size() != 0; i++)
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset state
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

      // Single set through an idle pipe: carry ripples across every stage
      chkLat = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      drainPipe();

      // Carry-in and all-ones corner
      applyStimulus(1'b0, 1'b1, 16'h1234, 16'h0FED, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
      drainPipe();

      // Eight back-to-back sets, one result per cycle
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b0, 1'b1, 16'(i * 16'h1357 + 16'h0F0F),
                       16'(16'hF00D - i * 16'h0321), 1'(i & 1), 1'b1);
      drainPipe();
      chkLat = 1'b0;

      // Fill the pipe with the output stalled, hold it, then release
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b1, 16'(16'hA000 + i * 16'h0111),
                       16'(16'h6FFF + i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
         checkOutput("full_in_ready", 32'(in_ready), 32'd0);
         checkOutput("full_out_valid", 32'(out_valid), 32'd1);
      end
      checkOutput("full_queue_depth", 32'(expQ.size()), 32'(STAGES));
      drainPipe();

      // Reset with three sets in flight
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 16'(16'h0100 * (i + 1)), 16'h00FF, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'h5555, 16'h5555, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
      drainPipe();

      // Random operands, random bubbles and random back-pressure
      for (int i = 0; i < 400; i++)
         applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom),
                       16'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      drainPipe();

      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

endmodule
